// File: rtl/vdma_sched_pkg.sv
// Shared definitions for the VDMA triple-buffer frame scheduler.
//
// Contents:
//   NUM_BUF    - number of frame buffers managed by the scheduler
//   buf_idx_t  - buffer index type (0..NUM_BUF-1)
//   W0/L0/R0   - write, latest and read indices after reset or disable
//   pick_free  - chooses the next write buffer given the read and latest buffers
package vdma_sched_pkg;

  localparam int NUM_BUF = 3;

  typedef logic [1:0] buf_idx_t;

  localparam buf_idx_t W0 = 2'd0;
  localparam buf_idx_t L0 = 2'd1;
  localparam buf_idx_t R0 = 2'd2;

  // Lowest buffer index that is neither being read nor holding the latest
  // complete frame. The loop runs downward so the lowest qualifying index is
  // the last one written. When r == l two buffers are free and the lower
  // one wins.
  function automatic buf_idx_t pick_free(input buf_idx_t r, input buf_idx_t l);
    buf_idx_t sel;
    sel = W0;
    for (int i = NUM_BUF - 1; i >= 0; i--) begin
      if ((buf_idx_t'(i) != r) && (buf_idx_t'(i) != l)) begin
        sel = buf_idx_t'(i);
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/vdma_sat_cnt.sv
// Saturating event counter.
//
// Ports:
//   clk_i  - clock
//   rst_i  - synchronous active-high reset, clears the count
//   clr_i  - synchronous clear, same effect as reset
//   inc_i  - add one on this edge unless already at all-ones
//   cnt_o  - registered count value
module vdma_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/vdma_frame_scheduler.sv
// Triple-buffer frame scheduler for a VDMA write/read pair.
//
// The writer always owns buffer W, the reader shows buffer R, and L holds the
// most recently completed frame. A write-side vsync completes the frame in W
// (once a frame has actually been started); a read-side vsync switches the
// reader to L if it has not been shown yet, otherwise the reader repeats R.
// Completed frames overwritten before being shown count as drops.
//
// Ports:
//   clock        - single clock
//   rst          - synchronous active-high reset (beats enable and events)
//   enable       - scheduler run; while low all state sits at reset values
//   base_addr    - address of buffer 0, stable while enable is high
//   wr_frame     - one-cycle pulse per write-side vsync
//   rd_frame     - one-cycle pulse per read-side vsync
//   wr_baseaddr  - base address of buffer W
//   rd_baseaddr  - base address of buffer R
//   wr_index     - buffer W
//   rd_index     - buffer R
//   trs_enable   - write path enable, enable delayed by one cycle
//   rev_enable   - read path enable, set at the first switch to a real frame
//   drop_cnt     - saturating count of dropped frames
//   repeat_cnt   - saturating count of repeated frames
//
// All outputs are registered: an event sampled at edge N shows after edge N.
module vdma_frame_scheduler
  import vdma_sched_pkg::*;
#(
  parameter int              ASIZE        = 29,
  parameter logic [ASIZE-1:0] FRAME_STRIDE = ASIZE'(29'h0080_0000),
  parameter int              CSIZE        = 16
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             enable,
  input  logic [ASIZE-1:0] base_addr,
  input  logic             wr_frame,
  input  logic             rd_frame,
  output logic [ASIZE-1:0] wr_baseaddr,
  output logic [ASIZE-1:0] rd_baseaddr,
  output logic [1:0]       wr_index,
  output logic [1:0]       rd_index,
  output logic             trs_enable,
  output logic             rev_enable,
  output logic [CSIZE-1:0] drop_cnt,
  output logic [CSIZE-1:0] repeat_cnt
);

  buf_idx_t         w_q, w_d;
  buf_idx_t         r_q, r_d;
  buf_idx_t         l_q, l_d;
  logic             fresh_q, fresh_d;
  logic             wr_valid_q, wr_valid_d;
  logic             rev_q, rev_d;
  logic             trs_q;
  logic [ASIZE-1:0] wr_addr_q, wr_addr_d;
  logic [ASIZE-1:0] rd_addr_q, rd_addr_d;
  logic             wr_done;
  logic             drop_inc;
  logic             rep_inc;

  function automatic logic [ASIZE-1:0] buf_offset(input buf_idx_t idx);
    return {{(ASIZE-2){1'b0}}, idx} * FRAME_STRIDE;
  endfunction

  always_comb begin
    w_d        = w_q;
    r_d        = r_q;
    l_d        = l_q;
    fresh_d    = fresh_q;
    wr_valid_d = wr_valid_q;
    rev_d      = rev_q;
    wr_done    = 1'b0;
    drop_inc   = 1'b0;
    rep_inc    = 1'b0;

    if (enable) begin
      // Write side first so a same-cycle read sees the new L and fresh.
      if (wr_frame) begin
        if (!wr_valid_q) begin
          // First vsync only marks the start of a frame in W.
          wr_valid_d = 1'b1;
        end else begin
          wr_done  = 1'b1;
          drop_inc = fresh_q;
          l_d      = w_q;
          fresh_d  = 1'b1;
        end
      end

      if (rd_frame) begin
        if (fresh_d) begin
          r_d     = l_d;
          fresh_d = 1'b0;
          rev_d   = 1'b1;
        end else begin
          // Before the reader has ever switched there is nothing to repeat.
          rep_inc = rev_q;
        end
      end

      if (wr_done) begin
        w_d = pick_free(r_d, l_d);
      end
    end else begin
      w_d        = W0;
      r_d        = R0;
      l_d        = L0;
      fresh_d    = 1'b0;
      wr_valid_d = 1'b0;
      rev_d      = 1'b0;
    end

    // Addresses follow the next indices so index and address move together.
    wr_addr_d = base_addr + buf_offset(w_d);
    rd_addr_d = base_addr + buf_offset(r_d);
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      w_q        <= W0;
      r_q        <= R0;
      l_q        <= L0;
      fresh_q    <= 1'b0;
      wr_valid_q <= 1'b0;
      rev_q      <= 1'b0;
      trs_q      <= 1'b0;
      wr_addr_q  <= base_addr + buf_offset(W0);
      rd_addr_q  <= base_addr + buf_offset(R0);
    end else begin
      w_q        <= w_d;
      r_q        <= r_d;
      l_q        <= l_d;
      fresh_q    <= fresh_d;
      wr_valid_q <= wr_valid_d;
      rev_q      <= rev_d;
      trs_q      <= enable;
      wr_addr_q  <= wr_addr_d;
      rd_addr_q  <= rd_addr_d;
    end
  end

  vdma_sat_cnt #(.W(CSIZE)) u_drop_cnt (
    .clk_i (clock),
    .rst_i (rst),
    .clr_i (~enable),
    .inc_i (drop_inc),
    .cnt_o (drop_cnt)
  );

  vdma_sat_cnt #(.W(CSIZE)) u_repeat_cnt (
    .clk_i (clock),
    .rst_i (rst),
    .clr_i (~enable),
    .inc_i (rep_inc),
    .cnt_o (repeat_cnt)
  );

  assign wr_index    = w_q;
  assign rd_index    = r_q;
  assign wr_baseaddr = wr_addr_q;
  assign rd_baseaddr = rd_addr_q;
  assign trs_enable  = trs_q;
  assign rev_enable  = rev_q;

endmodule

// File: tb/tb_vdma_frame_scheduler.sv
// Bench for vdma_frame_scheduler. Each tick drives one cycle of inputs and
// queues the hand-computed outputs expected after the next rising edge; a
// monitor on the falling edge pops due entries and compares them.
module tb_vdma_frame_scheduler;

  localparam int               ASIZE  = 29;
  localparam int               CSIZE  = 4;
  localparam logic [ASIZE-1:0] STRIDE = 29'h0080_0000;

  localparam logic [3:0] F_WIDX  = 4'd0;
  localparam logic [3:0] F_RIDX  = 4'd1;
  localparam logic [3:0] F_WADDR = 4'd2;
  localparam logic [3:0] F_RADDR = 4'd3;
  localparam logic [3:0] F_TRS   = 4'd4;
  localparam logic [3:0] F_REV   = 4'd5;
  localparam logic [3:0] F_DROP  = 4'd6;
  localparam logic [3:0] F_REP   = 4'd7;

  typedef struct packed {
    int          cyc;
    logic [3:0]  fld;
    logic [31:0] val;
  } exp_t;

  // ---------------- clock / reset ----------------
  logic             clock = 1'b0;
  logic             rst;
  logic             enable;
  logic [ASIZE-1:0] base_addr;
  logic             wr_frame;
  logic             rd_frame;
  logic [ASIZE-1:0] wr_baseaddr;
  logic [ASIZE-1:0] rd_baseaddr;
  logic [1:0]       wr_index;
  logic [1:0]       rd_index;
  logic             trs_enable;
  logic             rev_enable;
  logic [CSIZE-1:0] drop_cnt;
  logic [CSIZE-1:0] repeat_cnt;

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  vdma_frame_scheduler #(
    .ASIZE        (ASIZE),
    .FRAME_STRIDE (STRIDE),
    .CSIZE        (CSIZE)
  ) dut (
    .clock       (clock),
    .rst         (rst),
    .enable      (enable),
    .base_addr   (base_addr),
    .wr_frame    (wr_frame),
    .rd_frame    (rd_frame),
    .wr_baseaddr (wr_baseaddr),
    .rd_baseaddr (rd_baseaddr),
    .wr_index    (wr_index),
    .rd_index    (rd_index),
    .trs_enable  (trs_enable),
    .rev_enable  (rev_enable),
    .drop_cnt    (drop_cnt),
    .repeat_cnt  (repeat_cnt)
  );

  // ---------------- scoreboard ----------------
  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  bit   drain = 1'b0;
  bit   drained = 1'b0;

  function automatic string fname(input logic [3:0] f);
    case (f)
      F_WIDX:  return "wr_index";
      F_RIDX:  return "rd_index";
      F_WADDR: return "wr_baseaddr";
      F_RADDR: return "rd_baseaddr";
      F_TRS:   return "trs_enable";
      F_REV:   return "rev_enable";
      F_DROP:  return "drop_cnt";
      default: return "repeat_cnt";
    endcase
  endfunction

  function automatic logic [31:0] get_field(input logic [3:0] f);
    case (f)
      F_WIDX:  return 32'(wr_index);
      F_RIDX:  return 32'(rd_index);
      F_WADDR: return 32'(wr_baseaddr);
      F_RADDR: return 32'(rd_baseaddr);
      F_TRS:   return 32'(trs_enable);
      F_REV:   return 32'(rev_enable);
      F_DROP:  return 32'(drop_cnt);
      default: return 32'(repeat_cnt);
    endcase
  endfunction

  always @(negedge clock) begin
    exp_t        e;
    logic [31:0] act;
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      e   = exp_q.pop_front();
      act = get_field(e.fld);
      total++;
      if (e.cyc != cyc || act !== e.val) begin
        bad++;
        $display("FAIL %s cyc=%0d due=%0d got=%h want=%h", fname(e.fld), cyc, e.cyc, act, e.val);
      end
    end
    if (drain && !drained) begin
      total++;
      if (exp_q.size() != 0) begin
        bad++;
        $display("FAIL leftover got=%0d pending want=0", exp_q.size());
      end
      drained = 1'b1;
    end
  end

  // ---------------- driver tasks ----------------
  function automatic logic [ASIZE-1:0] addr_of(input logic [ASIZE-1:0] b, input int idx);
    logic [ASIZE-1:0] k;
    k = ASIZE'(idx);
    return b + k * STRIDE;
  endfunction

  task automatic push(input logic [3:0] f, input logic [31:0] v);
    exp_t e;
    e.cyc = cyc + 1;
    e.fld = f;
    e.val = v;
    exp_q.push_back(e);
  endtask

  // Drive one cycle and queue the full expected output set after the edge.
  task automatic tick(input bit wf, input bit rf, input bit en, input bit rs,
                      input int w, input int r, input bit trs, input bit rev,
                      input int d, input int p);
    rst      = rs;
    enable   = en;
    wr_frame = wf;
    rd_frame = rf;
    push(F_WIDX,  32'(w));
    push(F_RIDX,  32'(r));
    push(F_WADDR, 32'(addr_of(base_addr, w)));
    push(F_RADDR, 32'(addr_of(base_addr, r)));
    push(F_TRS,   32'(trs));
    push(F_REV,   32'(rev));
    push(F_DROP,  32'(d));
    push(F_REP,   32'(p));
    @(negedge clock);
    wr_frame = 1'b0;
    rd_frame = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end

  // ---------------- directed stimulus ----------------
  initial begin
    rst       = 1'b1;
    enable    = 1'b0;
    wr_frame  = 1'b0;
    rd_frame  = 1'b0;
    base_addr = 29'h0100_0000;
    @(negedge clock);

    // Reset values.
    tick(0, 0, 0, 1, 0, 2, 0, 0, 0, 0);
    // Enable: trs follows one cycle later, reader still off.
    tick(0, 0, 1, 0, 0, 2, 1, 0, 0, 0);
    for (int i = 0; i < 8; i++) tick(0, 0, 1, 0, 0, 2, 1, 0, 0, 0);
    // First wr_frame only starts a frame.
    tick(1, 0, 1, 0, 0, 2, 1, 0, 0, 0);
    for (int i = 0; i < 9; i++) tick(0, 0, 1, 0, 0, 2, 1, 0, 0, 0);
    // Completion: L=0, W=1.
    tick(1, 0, 1, 0, 1, 2, 1, 0, 0, 0);
    for (int i = 0; i < 9; i++) tick(0, 0, 1, 0, 1, 2, 1, 0, 0, 0);
    // Read switches to buffer 0 at base_addr.
    tick(0, 1, 1, 0, 1, 0, 1, 1, 0, 0);
    push(F_RADDR, 32'(29'h0100_0000));
    tick(0, 0, 1, 0, 1, 0, 1, 1, 0, 0);
    // Three more reads with nothing new: repeats.
    tick(0, 1, 1, 0, 1, 0, 1, 1, 0, 1);
    tick(0, 1, 1, 0, 1, 0, 1, 1, 0, 2);
    tick(0, 1, 1, 0, 1, 0, 1, 1, 0, 3);
    // Completion with fresh=0: L=1, W=2, no drop.
    tick(1, 0, 1, 0, 2, 0, 1, 1, 0, 3);
    // Completion with fresh=1: drop, L=2, W=1.
    tick(1, 0, 1, 0, 1, 0, 1, 1, 1, 3);
    // Simultaneous, fresh=1: drop, L=1, R=1, W=0.
    tick(1, 1, 1, 0, 0, 1, 1, 1, 2, 3);
    // Simultaneous, fresh=0: L=0 then R=0, W=1, no repeat.
    tick(1, 1, 1, 0, 1, 0, 1, 1, 2, 3);
    // Read with nothing new: repeat.
    tick(0, 1, 1, 0, 1, 0, 1, 1, 2, 4);

    // Reset mid-frame beats enable and events.
    tick(1, 1, 1, 1, 0, 2, 0, 0, 0, 0);
    tick(0, 0, 1, 0, 0, 2, 1, 0, 0, 0);
    tick(1, 0, 1, 0, 0, 2, 1, 0, 0, 0);
    // Read before any frame: no switch, no repeat.
    tick(0, 1, 1, 0, 0, 2, 1, 0, 0, 0);
    tick(1, 0, 1, 0, 1, 2, 1, 0, 0, 0);

    // Enable low: back to reset values, events ignored.
    tick(1, 1, 0, 0, 0, 2, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0, 2, 0, 0, 0, 0);
    tick(0, 0, 1, 0, 0, 2, 1, 0, 0, 0);
    // wr_valid was cleared: this only starts a frame.
    tick(1, 0, 1, 0, 0, 2, 1, 0, 0, 0);

    // Three writes from a clean start give one drop.
    tick(0, 0, 1, 1, 0, 2, 0, 0, 0, 0);
    tick(0, 0, 1, 0, 0, 2, 1, 0, 0, 0);
    tick(1, 0, 1, 0, 0, 2, 1, 0, 0, 0);
    tick(1, 0, 1, 0, 1, 2, 1, 0, 0, 0);
    tick(1, 0, 1, 0, 0, 2, 1, 0, 1, 0);

    // Address wrap and drop saturation.
    tick(0, 0, 0, 0, 0, 2, 0, 0, 0, 0);
    base_addr = 29'h1FFF_FFF0;
    tick(0, 0, 0, 0, 0, 2, 0, 0, 0, 0);
    push(F_RADDR, 32'(29'h00FF_FFF0));
    tick(0, 0, 1, 0, 0, 2, 1, 0, 0, 0);
    tick(1, 0, 1, 0, 0, 2, 1, 0, 0, 0);
    push(F_WADDR, 32'(29'h007F_FFF0));
    tick(1, 0, 1, 0, 1, 2, 1, 0, 0, 0);
    for (int k = 1; k <= 20; k++) begin
      tick(1, 0, 1, 0, (k % 2 == 1) ? 0 : 1, 2, 1, 0, (k > 15) ? 15 : k, 0);
    end
    tick(0, 0, 1, 0, 1, 2, 1, 0, 15, 0);

    drain = 1'b1;
    for (int i = 0; i < 5 && !drained; i++) @(negedge clock);
    if (!drained) begin
      total++;
      bad++;
      $display("FAIL drain got=stalled want=done");
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vdma_frame_scheduler.md
VDMA_FRAME_SCHEDULER -- requirements
Module: vdma_frame_scheduler

Interface
- REQ-001 SHALL have parameter ASIZE, default 29, meaning the address width matching the VDMA port baseaddr inputs.
- REQ-002 SHALL have parameter FRAME_STRIDE, default 29'h0080_0000, meaning the address distance between consecutive frame buffers.
- REQ-003 SHALL have parameter CSIZE, default 16, meaning the statistics counter width.
- REQ-004 SHALL use one clock and a synchronous, active-high reset; the clock port is clock and the reset port is rst (polarity and synchronicity fixed).
- REQ-005 SHALL have port clock, input, 1 bit: the single clock; all I/O is synchronous to it.
- REQ-006 SHALL have port rst, input, 1 bit: synchronous active-high reset.
- REQ-007 SHALL have port enable, input, 1 bit: scheduler run.
- REQ-008 SHALL have port base_addr, input, ASIZE bits: buffer 0 address; must be stable while enable=1.
- REQ-009 SHALL have port wr_frame, input, 1 bit: single-cycle pulse at each write-side vsync.
- REQ-010 SHALL have port rd_frame, input, 1 bit: single-cycle pulse at each read-side vsync.
- REQ-011 SHALL have port wr_baseaddr, output, ASIZE bits: address of the buffer being written.
- REQ-012 SHALL have port rd_baseaddr, output, ASIZE bits: address of the buffer being read.
- REQ-013 SHALL have port wr_index and port rd_index, each output, 2 bits: the current write and read buffer numbers.
- REQ-014 SHALL have port trs_enable and port rev_enable, each output, 1 bit: enables for the VDMA write path and read path.
- REQ-015 SHALL have port drop_cnt and port repeat_cnt, each output, CSIZE bits: counts of dropped and repeated frames.

Function
- REQ-016 SHALL manage exactly 3 buffers via registers W (write), R (read) and L (latest complete), plus flags fresh (L not yet shown) and wr_valid (W holds a frame in progress).
- REQ-017 SHALL, on wr_frame with wr_valid=0: set wr_valid=1 and leave W, L and fresh unchanged.
- REQ-018 SHALL, on wr_frame with wr_valid=1: increment drop_cnt if fresh=1, then set L=W and fresh=1.
- REQ-019 SHALL, on rd_frame with fresh=1: set R=L (using the L computed this cycle), fresh=0 and rev_enable=1.
- REQ-020 SHALL, on rd_frame with fresh=0: leave R unchanged and increment repeat_cnt only if rev_enable=1.
- REQ-021 SHALL, when wr_frame and rd_frame arrive in the same cycle, apply the write update first; the reader then sees the new L and fresh.
- REQ-022 SHALL, after any write-side completion, set new W = lowest index not in {new R, new L}, so W never equals R or L.
- REQ-023 SHALL make wr_baseaddr = base_addr + W*FRAME_STRIDE and rd_baseaddr = base_addr + R*FRAME_STRIDE, truncated modulo 2^ASIZE.
- REQ-024 SHALL register all outputs: an event in cycle N is visible at cycle N+1, with index and address changing in the same cycle.
- REQ-025 SHALL make drop_cnt and repeat_cnt saturate at all-ones.
- REQ-026 SHALL make trs_enable a registered copy of enable (1-cycle latency).
- REQ-027 SHALL hold rev_enable=0 until the first R update after enable.
- REQ-028 SHALL, while enable=0, hold all state at reset values and ignore wr_frame/rd_frame; deassertion mid-frame behaves as reset at the next edge.

Reset
- REQ-029 SHALL, on rst=1 at a clock edge, set W=0, L=1, R=2, fresh=0, wr_valid=0, trs_enable=0, rev_enable=0, drop_cnt=0, repeat_cnt=0.
- REQ-030 SHALL, on the edge after rst or enable deassertion, drive wr_baseaddr=base_addr and rd_baseaddr=base_addr+2*FRAME_STRIDE.
- REQ-031 SHALL give rst priority over enable and over all event inputs.

Structure
- REQ-032 SHALL declare the following in shared package vdma_sched_pkg: NUM_BUF=3, typedef buf_idx_t (logic [1:0]), and the reset index constants W0=0, L0=1, R0=2.
- REQ-033 SHALL implement the index-selection logic (REQ-022) as a function in vdma_sched_pkg.
- REQ-034 SHALL instantiate sub-module vdma_sat_cnt (increment, saturate, synchronous clear) twice, once for drops and once for repeats.

Verification
- REQ-035 SHALL cover the basic sequence: enable=1; wr_frame at cycles 10 and 20; rd_frame at cycle 30 -> wr_index=1 from cycle 21, rd_index=0 and rev_enable=1 at cycle 31, rd_baseaddr=base_addr.
- REQ-036 SHALL cover drops: three wr_frame pulses with no rd_frame after the initial one -> drop_cnt=1; W never equals R or L.
- REQ-037 SHALL cover repeats: rd_frame ×4 with no write completion after the first read -> repeat_cnt=3; rd_index unchanged.
- REQ-038 SHALL cover simultaneous events: wr_frame and rd_frame in the same cycle with wr_valid=1 -> R = the old W, fresh=0, W = the remaining index.
- REQ-039 SHALL cover saturation and wrap: CSIZE=4 with 20 drops -> drop_cnt=15; base_addr=29'h1FFF_FFF0 -> addresses wrap modulo 2^29.
- REQ-040 SHALL cover reset mid-frame: rst pulse after activity -> all outputs return to REQ-029/REQ-030 values one edge later; a following wr_frame only sets wr_valid.
